// File: rtl/chan_scan_mux_pkg.sv
// chan_scan_mux shared types
// FSM state encoding and mode constants
package chan_scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAN,
        SCAN,
        WAIT
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_scan_ptr.sv
// chan_scan_mux scan pointer
// Wrapping channel pointer plus saturating dwell counter
module scan_ptr
    import chan_scan_mux_pkg::*;
#(
    parameter int CH    = 8,
    parameter int DWELL = 1,
    localparam int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    output logic [SELW-1:0] ptr,
    output logic            last,
    output logic            dwell_done
);

    logic [7:0] cnt;

    assign last       = (ptr == SELW'(CH - 1));
    assign dwell_done = (32'(cnt) + 32'd1) >= 32'(DWELL);

    // Pointer: cleared on scan entry, steps (and wraps) on each scan load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= last ? '0 : ptr + 1'b1;
        end
    end

    // Dwell counter restarts at every load and free-runs otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || adv) begin
            cnt <= '0;
        end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered CH:1 channel mux, manual or scan select
// Optional q_par output when CHAN_SCAN_MUX_PARITY_EN is defined
module chan_scan_mux
    import chan_scan_mux_pkg::*;
#(
    parameter int CH    = 8,
    parameter int W     = 8,
    parameter int DWELL = 1,
    localparam int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [SELW-1:0] sel_in,
    input  logic [CH*W-1:0] d,
    output logic [W-1:0]    q,
    output logic [SELW-1:0] q_sel,
    output logic            q_valid,
    input  logic            q_ready,
    output logic            sel_err,
    output logic            scan_done
`ifdef CHAN_SCAN_MUX_PARITY_EN
    ,
    output logic            q_par
`endif
);

    state_t state, nxt;

    logic [SELW-1:0] ptr;
    logic            last;
    logic            dwell_done;
    logic            gate;
    logic            load;
    logic            clr;
    logic            adv;
    logic [SELW-1:0] lsel;
    logic            lerr;
    logic [W-1:0]    ldat;

    scan_ptr #(
        .CH    (CH),
        .DWELL (DWELL)
    ) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .adv        (adv),
        .ptr        (ptr),
        .last       (last),
        .dwell_done (dwell_done)
    );

    // Source select and load qualification for the output register
    always_comb begin
        lsel = (state == SCAN) ? ptr : sel_in;
        lerr = (state != SCAN) && (32'(sel_in) >= 32'(CH));
        ldat = '0;
        if (!lerr) begin
            ldat = d[32'(lsel)*W +: W];
        end
        gate = (state == MAN) || (state == SCAN);
        load = en && (!q_valid || q_ready) && gate;
        adv  = load && (state == SCAN);
        clr  = en && (mode == MODE_SCAN)
            && ((state == IDLE) || (state == MAN));
    end

    // Next-state: en low always parks in IDLE; mode picks MAN or SCAN
    always_comb begin
        nxt = state;
        if (!en) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, MAN: begin
                    nxt = (mode == MODE_SCAN) ? SCAN : MAN;
                end
                SCAN: begin
                    if (mode == MODE_MANUAL) begin
                        nxt = MAN;
                    end else if (adv && (DWELL > 0)) begin
                        nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (mode == MODE_MANUAL) begin
                        nxt = MAN;
                    end else if (dwell_done) begin
                        nxt = SCAN;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Output register: load replaces, accept without load empties, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            q_sel     <= '0;
            q_valid   <= 1'b0;
            sel_err   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= adv && last;
            if (load) begin
                q       <= ldat;
                q_sel   <= lsel;
                sel_err <= lerr;
                q_valid <= 1'b1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

`ifdef CHAN_SCAN_MUX_PARITY_EN
    // Even parity of the loaded word, held alongside q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_par <= 1'b0;
        end else if (load) begin
            q_par <= ^ldat;
        end
    end
`endif

endmodule
